// File: rtl/sub16_serial.sv
// ---------------------------------------------------------------------------
// sub16_serial
//
// Nibble-serial subtractor that computes a - b - Bin one NIB-bit slice per
// clock. The borrow between slices is carried in an internal flag. It is the
// low-area subtract counterpart of the carry-lookahead adder in the ALU
// datapath. Operands are latched when start is accepted, and results hold
// until the next accepted start.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   a      minuend, sampled when start is accepted in IDLE
//   b      subtrahend, sampled when start is accepted in IDLE
//   Bin    borrow in (active-high), sampled when start is accepted
//   start  operation request; only honoured in IDLE
//   diff   (a - b - Bin) mod 2^WIDTH, valid from the done cycle
//   Bout   borrow out: 1 iff unsigned a < b + Bin
//   ovf    signed overflow of a - b - Bin
//   zero   diff == 0
//   busy   high while slices are being computed (RUN)
//   done   one-cycle pulse when results become valid
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module sub16_serial #(
  parameter int NIB   = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Bin,
  input  logic             start,
  output logic [WIDTH-1:0] diff,
  output logic             Bout,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int SLICES = WIDTH / NIB;
  localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic               borrow;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;

  logic [NIB-1:0]     a_slice;
  logic [NIB-1:0]     b_slice;
  logic [NIB:0]       slice_sum;
  logic               slice_carry;
  logic [WIDTH-1:0]   diff_next;
  logic               last_slice;

  assign last_slice = (cnt == CNT_W'(SLICES - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. DONE always returns to IDLE, so a start that is held
  // high is accepted one cycle later. This gives one operation per 6 cycles.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_slice) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The status outputs decode the state directly. busy and done come from
  // different states, so they can never be high together.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Slice select and slice arithmetic. Subtraction is a + ~b + ~borrow. The
  // carry out of a slice is the inverse of the borrow into the next slice.
  // Slices are selected with constant part-selects so that every index is
  // static.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int i = 0; i < SLICES; i++) begin
      if (cnt == CNT_W'(i)) begin
        a_slice = a_q[i*NIB +: NIB];
        b_slice = b_q[i*NIB +: NIB];
      end
    end
    slice_sum   = {1'b0, a_slice} + {1'b0, ~b_slice} + {{NIB{1'b0}}, ~borrow};
    slice_carry = slice_sum[NIB];
    diff_next   = diff;
    for (int i = 0; i < SLICES; i++) begin
      if (cnt == CNT_W'(i)) begin
        diff_next[i*NIB +: NIB] = slice_sum[NIB-1:0];
      end
    end
  end

  // Datapath registers. Operands are copied on acceptance, so input changes
  // during RUN cannot corrupt the result. The flags are computed from the
  // complete diff_next on the last slice, so they change only on entry to
  // DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      diff   <= '0;
      Bout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            borrow <= Bin;
            cnt    <= '0;
          end
        end
        RUN: begin
          diff   <= diff_next;
          borrow <= ~slice_carry;
          cnt    <= cnt + CNT_W'(1);
          if (last_slice) begin
            Bout <= ~slice_carry;
            ovf  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                    (diff_next[WIDTH-1] != a_q[WIDTH-1]);
            zero <= (diff_next == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub16_serial.sv
// ---------------------------------------------------------------------------
// tb_sub16_serial
//
// Directed bench for sub16_serial. It checks the reset values, hand-computed
// subtraction vectors, latency and busy length, that start is ignored during
// RUN, that a reset in mid-RUN aborts the operation, and a sweep with start
// held high against a 17-bit reference.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sub16_serial;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        Bin;
  logic        start;
  logic [15:0] diff;
  logic        Bout;
  logic        ovf;
  logic        zero;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  sub16_serial dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .Bin   (Bin),
    .start (start),
    .diff  (diff),
    .Bout  (Bout),
    .ovf   (ovf),
    .zero  (zero),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. It drives the operands and raises start so that the
  // next posedge accepts the request.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                               input logic bin);
    a     = av;
    b     = bv;
    Bin   = bin;
    start = 1'b1;
  endtask

  // Steps through negedges until done is seen, within a bounded number of
  // cycles. It records the latency in negedges and the number of busy
  // cycles, and drops start after the first edge unless keepStart is set.
  task automatic waitDone(input bit keepStart, output int lat,
                          output int busyCnt, output bit seen);
    lat     = 0;
    busyCnt = 0;
    seen    = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (!keepStart) start = 1'b0;
      checkOutput("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
      if (busy) busyCnt++;
      if (done) begin
        lat  = i;
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic checkResult(input string tag, input int lat, input int busyCnt,
                             input bit seen, input int expLat, input int expBusy,
                             input logic [15:0] expDiff, input logic expBout,
                             input logic expOvf, input logic expZero);
    checkOutput({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_busy_cycles"}, busyCnt, expBusy);
    checkOutput({tag, "_diff"}, {16'd0, diff}, {16'd0, expDiff});
    checkOutput({tag, "_Bout"}, {31'd0, Bout}, {31'd0, expBout});
    checkOutput({tag, "_ovf"}, {31'd0, ovf}, {31'd0, expOvf});
    checkOutput({tag, "_zero"}, {31'd0, zero}, {31'd0, expZero});
  endtask

  initial begin
    int          lat;
    int          busyCnt;
    bit          seen;
    int          doneCnt;
    int          busySeen;
    logic [15:0] av;
    logic [15:0] bv;
    logic        bin;
    logic [16:0] ref17;

    rst   = 1'b1;
    a     = '0;
    b     = '0;
    Bin   = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    checkOutput("reset_diff", {16'd0, diff}, 32'd0);
    checkOutput("reset_Bout", {31'd0, Bout}, 32'd0);
    checkOutput("reset_ovf", {31'd0, ovf}, 32'd0);
    checkOutput("reset_zero", {31'd0, zero}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic subtraction, latency and busy length
    applyStimulus(16'h1234, 16'h0234, 1'b0);
    waitDone(1'b0, lat, busyCnt, seen);
    checkResult("t1", lat, busyCnt, seen, 5, 4, 16'h1000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t1_done_one_cycle", {31'd0, done}, 32'd0);
    checkOutput("t1_hold_diff", {16'd0, diff}, 32'h1000);

    // Unsigned wrap
    applyStimulus(16'h0000, 16'h0001, 1'b0);
    waitDone(1'b0, lat, busyCnt, seen);
    checkResult("t2", lat, busyCnt, seen, 5, 4, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    // Signed overflow, both directions
    applyStimulus(16'h8000, 16'h0001, 1'b0);
    waitDone(1'b0, lat, busyCnt, seen);
    checkResult("t3a", lat, busyCnt, seen, 5, 4, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(16'h7FFF, 16'hFFFF, 1'b0);
    waitDone(1'b0, lat, busyCnt, seen);
    checkResult("t3b", lat, busyCnt, seen, 5, 4, 16'h8000, 1'b1, 1'b1, 1'b0);
    @(negedge clk);

    // Borrow in: exact zero, then a=b with Bin wraps to all ones
    applyStimulus(16'h0005, 16'h0004, 1'b1);
    waitDone(1'b0, lat, busyCnt, seen);
    checkResult("t4a", lat, busyCnt, seen, 5, 4, 16'h0000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(16'hABCD, 16'hABCD, 1'b1);
    waitDone(1'b0, lat, busyCnt, seen);
    checkResult("t4b", lat, busyCnt, seen, 5, 4, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    // start and operand changes during RUN are ignored and not queued
    applyStimulus(16'h0050, 16'h0020, 1'b0);
    @(negedge clk);
    a     = 16'hFFFF;
    b     = 16'h0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(1'b0, lat, busyCnt, seen);
    checkResult("t5", lat, busyCnt, seen, 3, 2, 16'h0030, 1'b0, 1'b0, 1'b0);
    busySeen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy) busySeen++;
    end
    checkOutput("t5_no_queued_op", busySeen, 0);

    // Reset on the second RUN cycle aborts and clears everything
    applyStimulus(16'h4321, 16'h0021, 1'b0);
    @(negedge clk);
    a     = 16'h1111;
    b     = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    #1;
    checkOutput("t6_rst_diff", {16'd0, diff}, 32'd0);
    checkOutput("t6_rst_Bout", {31'd0, Bout}, 32'd0);
    checkOutput("t6_rst_ovf", {31'd0, ovf}, 32'd0);
    checkOutput("t6_rst_zero", {31'd0, zero}, 32'd0);
    checkOutput("t6_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("t6_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) doneCnt++;
    end
    checkOutput("t6_no_done_after_abort", doneCnt, 0);
    applyStimulus(16'h9000, 16'h1000, 1'b0);
    waitDone(1'b0, lat, busyCnt, seen);
    checkResult("t6_next", lat, busyCnt, seen, 5, 4, 16'h8000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Sweep with start held high: a new op is accepted every 6 cycles
    av  = 16'($urandom_range(0, 999));
    bv  = 16'($urandom_range(0, 999));
    bin = 1'($urandom_range(0, 1));
    applyStimulus(av, bv, bin);
    for (int n = 0; n < 40; n++) begin
      waitDone(1'b1, lat, busyCnt, seen);
      ref17 = {1'b0, av} - {1'b0, bv} - {16'd0, bin};
      checkResult("sweep", lat, busyCnt, seen, (n == 0) ? 5 : 6, 4, ref17[15:0],
                  ref17[16], (av[15] != bv[15]) && (ref17[15] != av[15]),
                  ref17[15:0] == 16'h0000);
      if (failures != 0) break;
      av  = 16'($urandom_range(0, 999));
      bv  = 16'($urandom_range(0, 999));
      bin = 1'($urandom_range(0, 1));
      a   = av;
      b   = bv;
      Bin = bin;
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
